pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 14 +
 rtl/pc_sequencer_next_sel.sv | 24 ++
 rtl/pc_sequencer.sv | 85 ++++++++
 tb/tb_pc_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: state encodings and constants shared by the PC sequencer files.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam int IMEM_BYTES_DEF = 128;
    localparam logic [7:0] PC_INC = 8'd4;

endpackage

// File: rtl/pc_sequencer_next_sel.sv
// pc_next_sel: combinational next-PC select; jump beats taken branch beats PC+4, all modulo 256.
module pc_next_sel
    import pc_seq_pkg::*;
(
    input  logic [7:0]  pc_i,
    input  logic        zero_i,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic [31:0] seimm_i,
    input  logic [25:0] jump_value_i,
    output logic [7:0]  next_pc_o
);

    logic [7:0] seq_pc;
    logic [7:0] br_pc;
    logic       unused_hi;

    assign seq_pc = pc_i + PC_INC;
    // Only the low offset bits matter once shifted into an 8-bit address space.
    assign br_pc = seq_pc + {seimm_i[5:0], 2'b00};
    assign next_pc_o = jump_i ? {jump_value_i[5:0], 2'b00} : (branch_i && zero_i) ? br_pc : seq_pc;
    assign unused_hi = ^{seimm_i[31:6], jump_value_i[25:6]};

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: run/step/halt PC sequencer with sticky PC-range fault.
// Define PC_RETIRE_CNT_EN to add the 16-bit RetireCnt output.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int IMEM_BYTES = IMEM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic        halt_req,
    input  logic        Zero,
    input  logic        Branch,
    input  logic        Jump,
    input  logic [31:0] SEImm,
    input  logic [25:0] JumpValue,
`ifdef PC_RETIRE_CNT_EN
    output logic [15:0] RetireCnt,
`endif
    output logic [7:0]  ReadAddr,
    output logic        Exec,
    output logic [1:0]  State,
    output logic        Fault
);

    localparam logic [8:0] LIMIT = 9'(IMEM_BYTES);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d, npc;
    logic       fault_q, fault_d;
    logic       oob, commit;

    pc_next_sel u_next_sel (
        .pc_i        (pc_q),
        .zero_i      (Zero),
        .branch_i    (Branch),
        .jump_i      (Jump),
        .seimm_i     (SEImm),
        .jump_value_i(JumpValue),
        .next_pc_o   (npc)
    );

    always_comb begin
        Exec = (state_q == RUN && !halt_req) || state_q == STEP;
        oob = {1'b0, npc} >= LIMIT;
        commit = Exec && !oob;
        pc_d = commit ? npc : pc_q;
        fault_d = fault_q || (Exec && oob);
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = run ? RUN : step ? STEP : IDLE;
            RUN:     state_d = (Exec && oob) ? FAULT : halt_req ? IDLE : RUN;
            STEP:    state_d = oob ? FAULT : IDLE;
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= 8'h00;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

`ifdef PC_RETIRE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        cnt_q <= reset ? 16'h0000 : cnt_q + 16'(commit);
    end

    assign RetireCnt = cnt_q;
`endif

    assign ReadAddr = pc_q;
    assign State = state_q;
    assign Fault = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; a reference model queues expected PC/state/fault per cycle.
module tb_pc_sequencer;

    localparam int IMEM = 128;

    logic        clk = 1'b0;
    logic        reset, run, step, halt_req, Zero, Branch, Jump;
    logic [31:0] SEImm;
    logic [25:0] JumpValue;
    logic [7:0]  ReadAddr;
    logic        Exec;
    logic [1:0]  State;
    logic        Fault;
`ifdef PC_RETIRE_CNT_EN
    logic [15:0] RetireCnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [1:0]  st;
        logic        f;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [7:0]  m_pc;
    logic [1:0]  m_st;
    logic        m_f;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .step     (step),
        .halt_req (halt_req),
        .Zero     (Zero),
        .Branch   (Branch),
        .Jump     (Jump),
        .SEImm    (SEImm),
        .JumpValue(JumpValue),
`ifdef PC_RETIRE_CNT_EN
        .RetireCnt(RetireCnt),
`endif
        .ReadAddr (ReadAddr),
        .Exec     (Exec),
        .State    (State),
        .Fault    (Fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic ru, input logic st, input logic h,
                       input logic z, input logic b, input logic j,
                       input logic [31:0] se = 32'h0, input logic [25:0] jv = 26'h0);
        int   npc;
        logic ex;
        exp_t e;
        {reset, run, step, halt_req, Zero, Branch, Jump} = {r, ru, st, h, z, b, j};
        SEImm = se;
        JumpValue = jv;
        #1;
        ex = (m_st == 2'd1 && !h) || m_st == 2'd2;
        check("exec", {31'b0, Exec}, {31'b0, ex});
        if (j) npc = int'(jv[5:0]) * 4;
        else if (b && z) npc = (int'(m_pc) + 4 + int'(se[5:0]) * 4) % 256;
        else npc = (int'(m_pc) + 4) % 256;
        if (r) begin
            m_pc = 8'h00; m_st = 2'd0; m_f = 1'b0; m_cnt = 16'h0;
        end else if (ex && npc >= IMEM) begin
            m_st = 2'd3; m_f = 1'b1;
        end else if (ex) begin
            m_pc = npc[7:0]; m_cnt = m_cnt + 16'd1; m_st = (m_st == 2'd2) ? 2'd0 : 2'd1;
        end else if (m_st == 2'd0) begin
            m_st = ru ? 2'd1 : st ? 2'd2 : 2'd0;
        end else if (m_st == 2'd1) begin
            m_st = 2'd0;
        end
        e.pc = m_pc; e.st = m_st; e.f = m_f; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("addr", {24'b0, ReadAddr}, {24'b0, e.pc});
        check("state", {30'b0, State}, {30'b0, e.st});
        check("fault", {31'b0, Fault}, {31'b0, e.f});
`ifdef PC_RETIRE_CNT_EN
        check("retire", {16'b0, RetireCnt}, {16'b0, e.cnt});
`endif
    endtask

    initial begin
        {reset, run, step, halt_req, Zero, Branch, Jump} = 7'b1000000;
        SEImm = 32'h0;
        JumpValue = 26'h0;
        repeat (2) @(posedge clk);
        #1;
        m_pc = 8'h00; m_st = 2'd0; m_f = 1'b0; m_cnt = 16'h0;
        check("rst_addr", {24'b0, ReadAddr}, 32'h0);
        check("rst_state", {30'b0, State}, 32'h0);
        check("rst_exec", {31'b0, Exec}, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // Sequential run from reset.
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("s20_exec", {31'b0, Exec}, 32'h1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        check("s20_pc", {24'b0, ReadAddr}, 32'h0C);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("s21_pc0", {24'b0, ReadAddr}, 32'h10);
        cyc(0, 0, 0, 0, 1, 1, 0, 32'hFFFF_FFFE);
        check("s21_taken", {24'b0, ReadAddr}, 32'h0C);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h4);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFE);
        check("s21_nt", {24'b0, ReadAddr}, 32'h14);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h8);
        cyc(0, 0, 0, 1, 0, 0, 1, 32'h0, 26'h3);
        check("s24_pc", {24'b0, ReadAddr}, 32'h20);
        check("s24_state", {30'b0, State}, 32'h0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        // Single step with a jump; run during STEP must be ignored.
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 32'h0, 26'h5);
        check("s22_pc", {24'b0, ReadAddr}, 32'h14);
        check("s22_state", {30'b0, State}, 32'h0);
        check("s22_exec", {31'b0, Exec}, 32'h0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        check("runwins", {30'b0, State}, 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h10);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check("s25_pc", {24'b0, ReadAddr}, 32'h0);
        check("s25_exec", {31'b0, Exec}, 32'h0);
        // Range fault at the top of memory.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h1F);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("s23_state", {30'b0, State}, 32'h3);
        check("s23_pc", {24'b0, ReadAddr}, 32'h7C);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 1, 32'h0, 26'h1);
        check("s23_hold", {24'b0, ReadAddr}, 32'h7C);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("s23_clr", {31'b0, Fault}, 32'h0);
        // Step jump to exactly IMEM_BYTES faults.
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h20);
        check("edge_state", {30'b0, State}, 32'h3);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // Backward branch wrapping below zero lands out of range.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 32'hFFFF_FFFC);
        check("wrap_fault", {31'b0, Fault}, 32'h1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 19) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
                1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, $urandom, 26'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
